// File: rtl/mips32_prog_loader.sv
// Boot-time program loader: takes a framed byte stream, writes big-endian words
// into instruction memory from address 0, checks an XOR checksum and releases the core.
module mips32_prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_en,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [16:0] MAX_N_C = 17'd1 << ADDR_W;

    state_t            state_r;
    state_t            state_s;
    logic [15:0]       n_r;
    logic [1:0]        byte_idx_r;
    logic [ADDR_W-1:0] word_idx_r;
    logic [7:0]        chk_r;
    logic [23:0]       shift_r;
    logic              xfer_s;
    logic              last_word_s;
    logic              restart_s;
    logic              busy_next_s;
    logic [16:0]       n_next_s;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    assign xfer_s      = s_valid && s_ready;
    assign n_next_s    = {1'b0, n_r[15:8], s_data};
    assign last_word_s = ((17'(word_idx_r) + 17'd1) == {1'b0, n_r});
    assign restart_s   = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
    assign busy_next_s = (state_s == HDR_HI) || (state_s == HDR_LO) ||
                         (state_s == DATA)   || (state_s == CHK);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the stream only advances the FSM on an accepted byte
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start) state_s = HDR_HI;
                else       state_s = state_r;
            end
            HDR_HI: begin
                if (xfer_s) state_s = HDR_LO;
                else        state_s = state_r;
            end
            HDR_LO: begin
                if (!xfer_s)                   state_s = state_r;
                else if (n_next_s == 17'd0)    state_s = CHK;
                else if (n_next_s > MAX_N_C)   state_s = ERR;
                else                           state_s = DATA;
            end
            DATA: begin
                if (xfer_s && (byte_idx_r == 2'd3) && last_word_s) state_s = CHK;
                else                                              state_s = state_r;
            end
            CHK: begin
                if (!xfer_s)               state_s = state_r;
                else if (s_data == chk_r)  state_s = DONE;
                else                       state_s = ERR;
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath and registered outputs; status outputs follow the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready      <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            cpu_en       <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            n_r          <= 16'd0;
            byte_idx_r   <= 2'd0;
            word_idx_r   <= '0;
            chk_r        <= 8'd0;
            shift_r      <= 24'd0;
        end else begin
            imem_we <= 1'b0;
            s_ready <= busy_next_s;
            busy    <= busy_next_s;
            cpu_en  <= (state_s == DONE);
            error   <= (state_s == ERR);
            if (restart_s) begin
                n_r          <= 16'd0;
                byte_idx_r   <= 2'd0;
                word_idx_r   <= '0;
                chk_r        <= 8'd0;
                words_loaded <= '0;
            end else if (xfer_s) begin
                case (state_r)
                    HDR_HI: begin
                        n_r[15:8] <= s_data;
                        chk_r     <= chk_update(chk_r, s_data);
                    end
                    HDR_LO: begin
                        n_r[7:0] <= s_data;
                        chk_r    <= chk_update(chk_r, s_data);
                    end
                    DATA: begin
                        chk_r      <= chk_update(chk_r, s_data);
                        shift_r    <= {shift_r[15:0], s_data};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= word_idx_r;
                            imem_wdata   <= {shift_r, s_data};
                            word_idx_r   <= word_idx_r + ADDR_W'(1);
                            words_loaded <= words_loaded + (ADDR_W+1)'(1);
                        end else begin
                            imem_we <= 1'b0;
                        end
                    end
                    default: begin
                        chk_r <= chk_r;
                    end
                endcase
            end else begin
                chk_r <= chk_r;
            end
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader (ADDR_W=4 so the length limit is reachable).
module tb_mips32_prog_loader;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_en;
    logic          busy;
    logic          error;
    logic [AW:0]   words_loaded;

    int total = 0;
    int bad = 0;
    int base;
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    logic [7:0]    f2 [0:9];

    mips32_prog_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_en(cpu_en), .busy(busy), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Log every memory write, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 20; i++) begin
            if (s_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!ok) check("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame1(input logic [7:0] chk);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h03, 0); send_byte(8'hE0, 0); send_byte(8'hA8, 0); send_byte(8'h00, 0);
        send_byte(chk, 0);
    endtask

    initial begin
        f2[0] = 8'h00; f2[1] = 8'h02; f2[2] = 8'h00; f2[3] = 8'h00; f2[4] = 8'h00;
        f2[5] = 8'h01; f2[6] = 8'hFF; f2[7] = 8'hFF; f2[8] = 8'hFF; f2[9] = 8'hFF;

        // reset state
        #12;
        check("reset_outputs", {s_ready, imem_we, imem_addr, imem_wdata, cpu_en, busy, error, words_loaded}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("idle_not_ready", {s_ready, busy}, 64'd0);

        // basic load with write timing
        base = wr_addr.size();
        pulse_start();
        check("t1_busy", {busy, s_ready}, 64'h3);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h03, 0); send_byte(8'hE0, 0); send_byte(8'hA8, 0);
        check("t1_no_early_we", imem_we, 64'd0);
        send_byte(8'h00, 0);
        check("t1_we_timing", {imem_we, imem_addr, imem_wdata}, {1'b1, 4'h0, 32'h03E0A800});
        send_byte(8'h4A, 0);
        check("t1_done", {cpu_en, error, busy, s_ready}, 64'h8);
        check("t1_words", words_loaded, 64'd1);
        check("t1_wr_count", wr_addr.size() - base, 64'd1);

        // reload from DONE, with gaps and a start pulse while busy
        pulse_start();
        check("reload_cpu_en_low", {cpu_en, busy, words_loaded}, {1'b0, 1'b1, 5'd0});
        base = wr_addr.size();
        for (int i = 0; i < 10; i++) begin
            send_byte(f2[i], (i % 3) + 1);
            if (i == 3) begin
                pulse_start();
                check("start_ignored_busy", {busy, words_loaded}, {1'b1, 5'd0});
            end
        end
        send_byte(8'h03, 2);
        check("t2_wr_count", wr_addr.size() - base, 64'd2);
        if (wr_addr.size() - base == 2) begin
            check("t2_w0", {wr_addr[base], wr_data[base]}, {4'h0, 32'h00000001});
            check("t2_w1", {wr_addr[base+1], wr_data[base+1]}, {4'h1, 32'hFFFFFFFF});
        end
        check("t2_done", {cpu_en, error, words_loaded}, {1'b1, 1'b0, 5'd2});

        // bad checksum keeps the written word
        pulse_start();
        base = wr_addr.size();
        send_frame1(8'h4B);
        check("t3_err", {error, cpu_en, s_ready, busy}, 64'h8);
        check("t3_wr_count", wr_addr.size() - base, 64'd1);
        if (wr_addr.size() - base == 1)
            check("t3_w0", {wr_addr[base], wr_data[base]}, {4'h0, 32'h03E0A800});
        pulse_start();
        check("t3_err_cleared", {error, busy}, 64'h1);
        send_frame1(8'h4A);
        check("t3_recover", {cpu_en, error}, 64'h2);

        // empty frame
        pulse_start();
        base = wr_addr.size();
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("t4_empty", {cpu_en, error, words_loaded}, {1'b1, 1'b0, 5'd0});
        check("t4_no_write", wr_addr.size() - base, 64'd0);

        // oversize length (17 > 16)
        pulse_start();
        base = wr_addr.size();
        send_byte(8'h00, 0); send_byte(8'h11, 0);
        check("t5_oversize", {error, busy, s_ready, cpu_en}, 64'h8);
        repeat (3) @(negedge clk);
        check("t5_no_write", wr_addr.size() - base, 64'd0);

        // reset in the middle of word 0
        pulse_start();
        base = wr_addr.size();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h03, 0); send_byte(8'hE0, 0); send_byte(8'hA8, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_reset", {s_ready, imem_we, imem_addr, imem_wdata, cpu_en, busy, error, words_loaded}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        s_valid = 1'b1; s_data = 8'h00;
        repeat (6) @(negedge clk);
        s_valid = 1'b0;
        check("t6_idle", {s_ready, busy, cpu_en, error, words_loaded}, 64'd0);
        check("t6_no_write", wr_addr.size() - base, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
